// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, drives the instruction-memory address and registers the
// returned word into a valid/ready slot for decode. Redirects (jr > jump > branch)
// squash the next capture; misaligned targets fault and halt, running past the end of
// instruction memory sets done and halts. Both halts are left only through reset.
// Optional: define FETCH_PERF_CNT_EN to add saturating fetch and bubble counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        done_o,
    output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam logic [31:0] EndAddr = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        adv;
    logic        redirect;
    logic        capture;
    logic [31:0] target;

    // Redirect target selection by priority; jumps take the region bits of the slot's PC+4.
    always_comb begin
        redirect = jr_i | jump_i | branch_i;
        if (jr_i) begin
            target = jr_target_i;
        end else if (jump_i) begin
            target = {slot_pc4_q[31:28], jump_index_i, 2'b00};
        end else begin
            target = branch_target_i;
        end
        adv = (state_q == StRun) & (~valid_q | ready_i);
    end

    // Next-state: sequencing, redirects, end-of-program and fault handling.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        slot_pc_d  = slot_pc_q;
        slot_pc4_d = slot_pc4_q;
        valid_d    = valid_q;
        done_d     = done_q;
        fault_d    = fault_q;
        capture    = 1'b0;
        case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (redirect) begin
                    // The slot is dropped whether or not decode took it this cycle.
                    valid_d = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (adv) begin
                    if (pc_q >= EndAddr) begin
                        state_d = StHalt;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        capture    = 1'b1;
                        instr_d    = imem_instr_i;
                        slot_pc_d  = pc_q;
                        slot_pc4_d = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                end
            end
            StHalt: begin
                if (valid_q && ready_i) valid_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output-slot registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            slot_pc_q  <= 32'h0;
            slot_pc4_q <= 32'd4;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            slot_pc_q  <= slot_pc_d;
            slot_pc4_q <= slot_pc4_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = slot_pc_q;
    assign pc_plus4_o  = slot_pc4_q;
    assign valid_o     = valid_q;
    assign done_o      = done_q;
    assign fault_o     = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble;

    // Saturating counter increments; a redirect cycle and an empty RUN cycle count once.
    always_comb begin
        bubble       = (state_q == StRun) & (redirect | ~valid_q);
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (capture && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (bubble && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 32-word instance for sequencing, stalls,
// redirects, fault and async reset, plus a 4-word instance for end of program.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance signals
    logic [31:0] imem_addr, imem_instr;
    logic        branch = 1'b0, jump = 1'b0, jr = 1'b0, ready = 1'b1;
    logic [31:0] branch_target = 32'h0, jr_target = 32'h0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] instr, pc, pc4;
    logic        valid, done, fault;

    // Small instance signals
    logic [31:0] s_imem_addr, s_imem_instr, s_instr, s_pc, s_pc4;
    logic        s_ready = 1'b1;
    logic        s_valid, s_done, s_fault;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt, bcnt, s_fcnt, s_bcnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory word i holds C0DE_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + (a >> 2);
    endfunction

    assign imem_instr   = mem_word(imem_addr);
    assign s_imem_instr = mem_word(s_imem_addr);

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_addr_o    (imem_addr),
        .imem_instr_i   (imem_instr),
        .branch_i       (branch),
        .branch_target_i(branch_target),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .jr_i           (jr),
        .jr_target_i    (jr_target),
        .instr_o        (instr),
        .pc_o           (pc),
        .pc_plus4_o     (pc4),
        .valid_o        (valid),
        .ready_i        (ready),
        .done_o         (done),
        .fault_o        (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o    (fcnt),
        .bubble_cnt_o   (bcnt)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) u_dut_small (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_addr_o    (s_imem_addr),
        .imem_instr_i   (s_imem_instr),
        .branch_i       (1'b0),
        .branch_target_i(32'h0),
        .jump_i         (1'b0),
        .jump_index_i   (26'h0),
        .jr_i           (1'b0),
        .jr_target_i    (32'h0),
        .instr_o        (s_instr),
        .pc_o           (s_pc),
        .pc_plus4_o     (s_pc4),
        .valid_o        (s_valid),
        .ready_i        (s_ready),
        .done_o         (s_done),
        .fault_o        (s_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o    (s_fcnt),
        .bubble_cnt_o   (s_bcnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_valid", {31'b0, valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc4", pc4, 32'd4);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_fault", {31'b0, fault}, 32'd0);

        // Sequential fetch: IDLE edge, then A at edge 2
        rst = 1'b0;
        tick();
        check_eq("idle_valid", {31'b0, valid}, 32'd0);
        tick();
        check_eq("a_valid", {31'b0, valid}, 32'd1);
        check_eq("a_instr", instr, 32'hC0DE_0000);
        check_eq("a_pc", pc, 32'h0);
        check_eq("a_addr", imem_addr, 32'd4);
        tick();
        check_eq("b_instr", instr, 32'hC0DE_0001);
        check_eq("b_pc", pc, 32'd4);

        // Stall three cycles holding B
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_instr", instr, 32'hC0DE_0001);
            check_eq("stall_pc", pc, 32'd4);
            check_eq("stall_addr", imem_addr, 32'd8);
            check_eq("stall_valid", {31'b0, valid}, 32'd1);
        end
        ready = 1'b1;
        tick();
        check_eq("c_instr", instr, 32'hC0DE_0002);
        check_eq("c_pc", pc, 32'd8);
        check_eq("c_pc4", pc4, 32'd12);

        // Jump to index 5 from slot pc 8
        jump = 1'b1;
        jump_index = 26'h5;
        tick();
        jump = 1'b0;
        check_eq("jmp_valid", {31'b0, valid}, 32'd0);
        check_eq("jmp_addr", imem_addr, 32'd20);
        tick();
        check_eq("jmp_instr", instr, 32'hC0DE_0005);
        check_eq("jmp_pc", pc, 32'd20);
        check_eq("jmp_pc4", pc4, 32'd24);

        // jr wins over branch
        jr = 1'b1;
        jr_target = 32'h40;
        branch = 1'b1;
        branch_target = 32'h10;
        tick();
        jr = 1'b0;
        branch = 1'b0;
        check_eq("jr_addr", imem_addr, 32'h40);
        check_eq("jr_valid", {31'b0, valid}, 32'd0);
        tick();
        check_eq("jr_instr", instr, 32'hC0DE_0010);
        check_eq("jr_pc", pc, 32'h40);

        // Misaligned branch faults and sticks
        branch = 1'b1;
        branch_target = 32'h12;
        tick();
        branch = 1'b0;
        check_eq("flt_fault", {31'b0, fault}, 32'd1);
        check_eq("flt_valid", {31'b0, valid}, 32'd0);
        check_eq("flt_addr", imem_addr, 32'h44);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("flt_stick", {31'b0, fault}, 32'd1);
            check_eq("flt_hold", {31'b0, valid}, 32'd0);
            check_eq("flt_addr_hold", imem_addr, 32'h44);
        end

        // Async reset mid-run with a valid slot
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mr_valid_pre", {31'b0, valid}, 32'd1);
        check_eq("mr_pc_pre", pc, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", {31'b0, valid}, 32'd0);
        check_eq("ar_pc", pc, 32'h0);
        check_eq("ar_addr", imem_addr, 32'h0);
        check_eq("ar_instr", instr, 32'h0);
        check_eq("ar_fault", {31'b0, fault}, 32'd0);

        // End of program on the 4-word instance
        tick();
        rst = 1'b0;
        s_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("eop_d_instr", s_instr, 32'hC0DE_0003);
        check_eq("eop_d_pc", s_pc, 32'd12);
        check_eq("eop_d_done", {31'b0, s_done}, 32'd0);
        s_ready = 1'b0;
        tick();
        check_eq("eop_hold_valid", {31'b0, s_valid}, 32'd1);
        check_eq("eop_hold_done", {31'b0, s_done}, 32'd0);
        s_ready = 1'b1;
        tick();
        check_eq("eop_done", {31'b0, s_done}, 32'd1);
        check_eq("eop_valid", {31'b0, s_valid}, 32'd0);
        check_eq("eop_pc", s_pc, 32'd12);
        check_eq("eop_instr", s_instr, 32'hC0DE_0003);
        check_eq("eop_addr", s_imem_addr, 32'd16);
        tick();
        check_eq("eop_stick", {31'b0, s_done}, 32'd1);
        check_eq("eop_nocap", {31'b0, s_valid}, 32'd0);
        check_eq("eop_nofault", {31'b0, s_fault}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
